// File: rtl/kernel_to_node_rom_arbiter.sv
// Round-robin arbiter sharing the kernel-to-node ROM between NUM_REQ lookup requesters.
// Each granted lookup reads the ROM once and returns the node number over a valid/ready response.
module kernel_to_node_rom_arbiter #(
   parameter int NUM_REQ              = 2,
   parameter int AXIS_LAN_TDEST_WIDTH = 8,
   parameter int NODE_ID_WIDTH        = 8,
   parameter int BRAM_ADDR_WIDTH      = 32
) (
   input  logic                                    i_clk,
   input  logic                                    i_ap_rst_n,
   input  logic [NUM_REQ-1:0]                      req_valid,
   output logic [NUM_REQ-1:0]                      req_ready,
   input  logic [NUM_REQ*AXIS_LAN_TDEST_WIDTH-1:0] req_kernel_id,
   output logic [NUM_REQ-1:0]                      resp_valid,
   input  logic [NUM_REQ-1:0]                      resp_ready,
   output logic [NODE_ID_WIDTH-1:0]                resp_node_id,
   output logic                                    kernel_to_node_ROM_CLK,
   output logic                                    kernel_to_node_ROM_RST,
   output logic                                    kernel_to_node_ROM_EN,
   output logic [BRAM_ADDR_WIDTH-1:0]              kernel_to_node_ROM_ADDR,
   input  logic [NODE_ID_WIDTH-1:0]                kernel_to_node_ROM_DOUT
);

   // Handshake: a request transfers on the edge where req_valid[i] && req_ready[i];
   // a response transfers on the edge where resp_valid[i] && resp_ready[i].
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]                      state_q, state_d;
   logic [IDX_W-1:0]                grant_q, grant_d;
   logic [IDX_W-1:0]                last_q, last_d;
   logic [NODE_ID_WIDTH-1:0]        node_q, node_d;

   logic                            any_req;
   logic [IDX_W-1:0]                win;
   logic [AXIS_LAN_TDEST_WIDTH-1:0] win_kid;

   // Scan starts just after the last winner so every requester gets a turn.
   always_comb begin
      any_req = 1'b0;
      win     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!any_req && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
            any_req = 1'b1;
            win     = IDX_W'((int'(last_q) + k) % NUM_REQ);
         end
      end
   end

   assign win_kid = req_kernel_id[int'(win)*AXIS_LAN_TDEST_WIDTH +: AXIS_LAN_TDEST_WIDTH];

   always_comb begin
      state_d                 = state_q;
      grant_d                 = grant_q;
      last_d                  = last_q;
      node_d                  = node_q;
      req_ready               = '0;
      resp_valid              = '0;
      kernel_to_node_ROM_EN   = 1'b0;
      kernel_to_node_ROM_ADDR = '0;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               req_ready[win]          = 1'b1;
               kernel_to_node_ROM_EN   = 1'b1;
               kernel_to_node_ROM_ADDR = BRAM_ADDR_WIDTH'({win_kid, 2'b00});
               grant_d                 = win;
               last_d                  = win;
               state_d                 = ST_READ;
            end
         end
         ST_READ: begin
            node_d  = kernel_to_node_ROM_DOUT;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            resp_valid[grant_q] = 1'b1;
            if (resp_ready[grant_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         node_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         node_q  <= node_d;
      end
   end

   assign resp_node_id           = node_q;
   assign kernel_to_node_ROM_CLK = i_clk;
   assign kernel_to_node_ROM_RST = ~i_ap_rst_n;

endmodule

// File: tb/tb_kernel_to_node_rom_arbiter.sv
// Bench for kernel_to_node_rom_arbiter: directed scenarios plus random traffic,
// checked every cycle against a lookup-level reference model with a node scoreboard.
module tb_kernel_to_node_rom_arbiter;

   localparam int N  = 4;
   localparam int KW = 8;
   localparam int NW = 8;
   localparam int AW = 32;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*KW-1:0] req_kernel_id;
   logic [N-1:0]    resp_valid;
   logic [N-1:0]    resp_ready;
   logic [NW-1:0]   resp_node_id;
   logic            rom_clk;
   logic            rom_rst;
   logic            rom_en;
   logic [AW-1:0]   rom_addr;
   logic [NW-1:0]   rom_dout;

   kernel_to_node_rom_arbiter #(
      .NUM_REQ(N), .AXIS_LAN_TDEST_WIDTH(KW), .NODE_ID_WIDTH(NW), .BRAM_ADDR_WIDTH(AW)
   ) dut (
      .i_clk                   (clk),
      .i_ap_rst_n              (rst_n),
      .req_valid               (req_valid),
      .req_ready               (req_ready),
      .req_kernel_id           (req_kernel_id),
      .resp_valid              (resp_valid),
      .resp_ready              (resp_ready),
      .resp_node_id            (resp_node_id),
      .kernel_to_node_ROM_CLK  (rom_clk),
      .kernel_to_node_ROM_RST  (rom_rst),
      .kernel_to_node_ROM_EN   (rom_en),
      .kernel_to_node_ROM_ADDR (rom_addr),
      .kernel_to_node_ROM_DOUT (rom_dout)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM behaves like a BRAM: data one cycle after EN, word index = byte address / 4.
   logic [NW-1:0] rom_mem [256];
   always @(posedge clk) begin
      if (rom_en) rom_dout <= rom_mem[rom_addr[9:2]];
   end

   int total;
   int bad;
   int cyc;

   // reference model: one lookup in flight, outcome known from the ROM table
   logic [NW-1:0] exp_q[$];
   bit            m_busy;
   int            m_acc;
   int            m_cur;
   int            m_last;
   logic [NW-1:0] m_shown;

   logic [N-1:0]  obs_ready;
   logic [N-1:0]  obs_rv;
   logic [AW-1:0] obs_addr;
   logic [NW-1:0] obs_node;
   int            grants;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [N*KW-1:0] pack4(input int a, input int b, input int c, input int d);
      logic [KW-1:0] ka, kb, kc, kd;
      ka = KW'(a); kb = KW'(b); kc = KW'(c); kd = KW'(d);
      return {kd, kc, kb, ka};
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_busy  = 0;
      m_acc   = 0;
      m_cur   = 0;
      m_last  = N - 1;
      m_shown = '0;
   endtask

   // one clock cycle: drive, check against the model, advance the model
   task automatic step(input logic [N-1:0] v, input logic [N*KW-1:0] k, input logic [N-1:0] rr);
      int            g;
      logic [N-1:0]  e_ready;
      logic [N-1:0]  e_rv;
      logic          e_en;
      logic [AW-1:0] e_addr;
      logic [NW-1:0] e_node;
      logic [KW-1:0] kid;
      @(negedge clk);
      req_valid     = v;
      req_kernel_id = k;
      resp_ready    = rr;
      #1;
      g = -1; e_ready = '0; e_rv = '0; e_en = 1'b0; e_addr = '0; e_node = m_shown; kid = '0;
      if (!m_busy) begin
         for (int i = 1; i <= N; i++) begin
            if (g < 0 && v[(m_last + i) % N]) g = (m_last + i) % N;
         end
         if (g >= 0) begin
            kid        = k[g*KW +: KW];
            e_ready[g] = 1'b1;
            e_en       = 1'b1;
            e_addr     = AW'(kid) * 4;
         end
      end else if (cyc >= m_acc + 2) begin
         e_rv[m_cur] = 1'b1;
         e_node      = exp_q[0];
      end
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("rom_en", 32'(rom_en), 32'(e_en));
      check("rom_addr", rom_addr, e_addr);
      check("resp_valid", 32'(resp_valid), 32'(e_rv));
      check("resp_node_id", 32'(resp_node_id), 32'(e_node));
      obs_ready = req_ready;
      obs_rv    = resp_valid;
      obs_addr  = rom_addr;
      obs_node  = resp_node_id;
      if (req_ready != '0) grants++;
      @(posedge clk);
      if (!m_busy && g >= 0) begin
         m_busy = 1; m_acc = cyc; m_cur = g; m_last = g;
         exp_q.push_back(rom_mem[kid]);
      end else if (m_busy && cyc >= m_acc + 2 && rr[m_cur]) begin
         m_shown = exp_q.pop_front();
         m_busy  = 0;
      end
      cyc++;
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; grants = 0;
      for (int i = 0; i < 256; i++) rom_mem[i] = NW'($urandom_range(0, 255));
      rom_mem[5] = 8'h03;
      rom_dout      = '0;
      req_valid     = '0;
      req_kernel_id = '0;
      resp_ready    = '0;
      rst_n         = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_rom_en", 32'(rom_en), 32'h0);
      check("rst_node", 32'(resp_node_id), 32'h0);
      check("rst_rom_rst", 32'(rom_rst), 32'h1);
      check("rom_clk", 32'(rom_clk), 32'(clk));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rom_rst_released", 32'(rom_rst), 32'h0);

      // single requester, kernel 5 -> address 0x14, node 0x03 two cycles later
      step(4'b0001, pack4(5, 0, 0, 0), 4'b0000);
      check("single_addr", obs_addr, 32'h14);
      check("single_ready", 32'(obs_ready), 32'h1);
      step(4'b0000, pack4(5, 0, 0, 0), 4'b0000);
      check("single_read_rv", 32'(obs_rv), 32'h0);
      step(4'b0000, pack4(5, 0, 0, 0), 4'b0001);
      check("single_rv", 32'(obs_rv), 32'h1);
      check("single_node", 32'(obs_node), 32'h03);
      step(4'b0000, pack4(5, 0, 0, 0), 4'b0000);
      check("single_idle_rv", 32'(obs_rv), 32'h0);

      // two requesters continuously valid: alternate, one lookup per 3 cycles
      grants = 0;
      for (int i = 0; i < 12; i++) step(4'b0011, pack4(1, 2, 0, 0), 4'b1111);
      check("alt_grant_count", 32'(grants), 32'd4);

      // backpressure on requester 0 while requester 1 waits
      step(4'b0001, pack4(7, 9, 0, 0), 4'b0000);
      check("bp_grant0", 32'(obs_ready), 32'h1);
      step(4'b0010, pack4(7, 9, 0, 0), 4'b0010);
      for (int i = 0; i < 5; i++) begin
         step(4'b0010, pack4(7, 9, 0, 0), 4'b0010);
         check("bp_hold_ready", 32'(obs_ready), 32'h0);
         check("bp_hold_node", 32'(obs_node), 32'(rom_mem[7]));
      end
      step(4'b0010, pack4(7, 9, 0, 0), 4'b0011);
      step(4'b0010, pack4(7, 9, 0, 0), 4'b0000);
      check("bp_grant1_after", 32'(obs_ready), 32'h2);
      step(4'b0000, '0, 4'b0000);
      step(4'b0000, '0, 4'b1111);

      // pointer wrap: last grant 3, then req2 and req0 -> req0, then req2
      step(4'b1000, pack4(0, 0, 0, 3), 4'b0000);
      step(4'b0000, '0, 4'b0000);
      step(4'b0000, '0, 4'b1111);
      step(4'b0101, pack4(4, 0, 6, 0), 4'b1111);
      check("wrap_first", 32'(obs_ready), 32'h1);
      step(4'b0101, pack4(4, 0, 6, 0), 4'b1111);
      step(4'b0101, pack4(4, 0, 6, 0), 4'b1111);
      step(4'b0101, pack4(4, 0, 6, 0), 4'b1111);
      check("wrap_second", 32'(obs_ready), 32'h4);
      step(4'b0000, '0, 4'b1111);
      step(4'b0000, '0, 4'b1111);

      // max kernel id
      step(4'b0001, pack4(255, 0, 0, 0), 4'b1111);
      check("max_addr", obs_addr, 32'h3FC);
      step(4'b0000, '0, 4'b1111);
      step(4'b0000, '0, 4'b1111);
      check("max_node", 32'(obs_node), 32'(rom_mem[255]));

      // reset during READ discards the lookup
      step(4'b0010, pack4(0, 12, 0, 0), 4'b1111);
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      #1;
      check("mid_rst_rv", 32'(resp_valid), 32'h0);
      check("mid_rst_node", 32'(resp_node_id), 32'h0);
      check("mid_rst_en", 32'(rom_en), 32'h0);
      @(posedge clk);
      #1;
      check("mid_rst_rv_edge", 32'(resp_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(4'b0000, '0, 4'b1111);
      check("post_rst_rv", 32'(obs_rv), 32'h0);
      step(4'b0011, pack4(3, 4, 0, 0), 4'b1111);
      check("post_rst_grant0", 32'(obs_ready), 32'h1);
      step(4'b0000, '0, 4'b1111);
      step(4'b0000, '0, 4'b1111);

      // random traffic
      for (int i = 0; i < 500; i++) begin
         step(N'($urandom_range(0, 15)),
              pack4($urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255)),
              N'($urandom_range(0, 15)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
